// File: rtl/spi_bram_bridge.sv
// ---------------------------------------------------------------------------
// spi_bram_bridge
//   SPI slave (mode 0) that turns command/address/data frames into accesses
//   on a single-port block RAM.
//
//   Frame: 1 command byte, ADDR_BYTES address bytes (MSB first, only the low
//   ADDR_W bits kept), then DATA_W-bit words.
//   0x02 = write burst, 0x03 = read burst, anything else is dropped. Address
//   auto-increments and wraps in both directions.
//   Read words are prefetched one word ahead so that MISO is ready on the
//   SCLK fall that starts each word.
//
//   Optional feature macro: SPI_BRAM_STATUS_EN adds command 0x05, which
//   returns a saturating count of invalid commands plus discarded partial
//   write words.
//
// Ports
//   sys_clk    system clock, everything on its rising edge
//   sys_rst    synchronous active-high reset
//   sclk_in    SPI clock (async, idle low)
//   mosi_in    SPI data in (async)
//   cs_in      SPI chip select, active low (async)
//   miso_out   SPI data out, 0 outside read data phases
//   addr_out   BRAM address
//   wdata_out  BRAM write data
//   rdata_in   BRAM read data, RD_LATENCY cycles after a read enable
//   wen_out    BRAM write enable
//   en_out     BRAM enable
// ---------------------------------------------------------------------------
module spi_bram_bridge #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              sclk_in,
    input  logic              mosi_in,
    input  logic              cs_in,
    output logic              miso_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] wdata_out,
    input  logic [DATA_W-1:0] rdata_in,
    output logic              wen_out,
    output logic              en_out
);

    localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
    localparam int ABITS      = ADDR_BYTES * 8;
    localparam logic [5:0] ADDR_LAST = 6'(ABITS - 1);
    localparam logic [5:0] DATA_LAST = 6'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, WDATA, RDATA, DROP, WAIT_CS
`ifdef SPI_BRAM_STATUS_EN
        , STATUS
`endif
    } state_t;

    state_t state, state_next;

    // Synchronisers; sclk keeps one extra stage for edge detection.
    // The CS chain resets to 0 (selected) so the FSM, which resets into
    // WAIT_CS, only leaves it once a genuine CS-high has been synchronised.
    logic [2:0] sclk_sr;
    logic [1:0] mosi_sr;
    logic [1:0] cs_sr;
    logic       sclk_rise, sclk_fall, mosi_s, cs_s;

    assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
    assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];
    assign mosi_s    = mosi_sr[1];
    assign cs_s      = cs_sr[1];

    logic [6:0]        cmd_sr;
    logic [7:0]        cmd_byte;
    logic              is_read;
    logic [5:0]        bit_cnt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-2:0] wshift;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] obuf;
    logic [RD_LATENCY:0] rd_pend;

    assign cmd_byte = {cmd_sr, mosi_s};

`ifdef SPI_BRAM_STATUS_EN
    logic [7:0] stat_cnt;
    logic [6:0] sbuf;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= WAIT_CS;
        else         state <= state_next;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so every path assigns state_next (no latch).
        state_next = state;
        case (state)
            IDLE:    if (!cs_s) state_next = CMD;
            CMD: begin
                if (cs_s) state_next = IDLE;
                else if (sclk_rise && bit_cnt == 6'd7) begin
                    if (cmd_byte == 8'h02 || cmd_byte == 8'h03) state_next = ADDR;
`ifdef SPI_BRAM_STATUS_EN
                    else if (cmd_byte == 8'h05) state_next = STATUS;
`endif
                    else state_next = DROP;
                end
            end
            ADDR: begin
                if (cs_s) state_next = IDLE;
                else if (sclk_rise && bit_cnt == ADDR_LAST)
                    state_next = is_read ? RDATA : WDATA;
            end
            WAIT_CS: if (cs_s) state_next = IDLE;
            default: if (cs_s) state_next = IDLE;   // WDATA, RDATA, DROP, STATUS
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sclk_sr   <= '0;
            mosi_sr   <= '0;
            cs_sr     <= '0;
            cmd_sr    <= '0;
            is_read   <= 1'b0;
            bit_cnt   <= '0;
            addr      <= '0;
            wshift    <= '0;
            hold      <= '0;
            obuf      <= '0;
            rd_pend   <= '0;
            miso_out  <= 1'b0;
            addr_out  <= '0;
            wdata_out <= '0;
            wen_out   <= 1'b0;
            en_out    <= 1'b0;
`ifdef SPI_BRAM_STATUS_EN
            stat_cnt  <= '0;
            sbuf      <= '0;
`endif
        end else begin
            // NOTE: non-blocking throughout; later assignments in this block
            // deliberately override the defaults set here.
            sclk_sr <= {sclk_sr[1:0], sclk_in};
            mosi_sr <= {mosi_sr[0], mosi_in};
            cs_sr   <= {cs_sr[0], cs_in};
            en_out  <= 1'b0;
            wen_out <= 1'b0;
            rd_pend <= {rd_pend[RD_LATENCY-1:0], 1'b0};
            if (rd_pend[RD_LATENCY]) hold <= rdata_in;

            case (state)
                CMD: begin
                    miso_out <= 1'b0;
                    if (sclk_rise) begin
                        cmd_sr  <= cmd_byte[6:0];
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd7) begin
                            bit_cnt <= '0;
                            is_read <= (cmd_byte == 8'h03);
`ifdef SPI_BRAM_STATUS_EN
                            if (cmd_byte != 8'h02 && cmd_byte != 8'h03 &&
                                cmd_byte != 8'h05 && stat_cnt != 8'hFF)
                                stat_cnt <= stat_cnt + 8'd1;
`endif
                        end
                    end
                end
                ADDR: begin
                    miso_out <= 1'b0;
                    if (sclk_rise) begin
                        // Excess high address bits simply shift out the top.
                        addr    <= ADDR_W'({addr, mosi_s});
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == ADDR_LAST) begin
                            bit_cnt <= '0;
                            if (is_read) begin
                                en_out     <= 1'b1;
                                addr_out   <= ADDR_W'({addr, mosi_s});
                                rd_pend[0] <= 1'b1;
                            end
                        end
                    end
                end
                WDATA: begin
                    miso_out <= 1'b0;
                    // A final bit arriving together with CS high still writes.
                    if (sclk_rise) begin
                        wshift  <= {wshift[DATA_W-3:0], mosi_s};
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt   <= '0;
                            en_out    <= 1'b1;
                            wen_out   <= 1'b1;
                            addr_out  <= addr;
                            wdata_out <= {wshift, mosi_s};
                            addr      <= addr + 1'b1;
                        end
                    end else if (cs_s) begin
                        bit_cnt <= '0;
`ifdef SPI_BRAM_STATUS_EN
                        if (bit_cnt != '0 && stat_cnt != 8'hFF)
                            stat_cnt <= stat_cnt + 8'd1;
`endif
                    end
                end
                RDATA: begin
                    if (cs_s) begin
                        miso_out <= 1'b0;
                    end else if (sclk_fall) begin
                        if (bit_cnt == '0) begin
                            // Word boundary: present the prefetched word and
                            // fetch the next one while it shifts out.
                            miso_out   <= hold[DATA_W-1];
                            obuf       <= hold << 1;
                            addr       <= addr + 1'b1;
                            addr_out   <= addr + 1'b1;
                            en_out     <= 1'b1;
                            rd_pend[0] <= 1'b1;
                            bit_cnt    <= 6'd1;
                        end else begin
                            miso_out <= obuf[DATA_W-1];
                            obuf     <= obuf << 1;
                            bit_cnt  <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + 6'd1;
                        end
                    end
                end
`ifdef SPI_BRAM_STATUS_EN
                STATUS: begin
                    if (cs_s) begin
                        miso_out <= 1'b0;
                    end else if (sclk_fall) begin
                        if (bit_cnt == '0) begin
                            miso_out <= stat_cnt[7];
                            sbuf     <= stat_cnt[6:0];
                        end else begin
                            miso_out <= sbuf[6];
                            sbuf     <= sbuf << 1;
                        end
                        bit_cnt <= (bit_cnt == 6'd7) ? '0 : bit_cnt + 6'd1;
                    end
                end
`endif
                default: begin   // IDLE, DROP, WAIT_CS
                    miso_out <= 1'b0;
                    bit_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_bram_bridge.sv
// ---------------------------------------------------------------------------
// tb_spi_bram_bridge
//   Directed bench: a table of SPI frames with hand-computed BRAM pulses and
//   MISO bytes, followed by hand-written sequences for partial words, reset
//   in the middle of a read, and CS rising together with a final bit.
// ---------------------------------------------------------------------------
module tb_spi_bram_bridge;

    localparam int HALF = 8;   // sys_clk cycles per SCLK phase

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        sclk_in = 1'b0;
    logic        mosi_in = 1'b0;
    logic        cs_in   = 1'b1;
    logic        miso_out;
    logic [12:0] addr_out;
    logic [7:0]  wdata_out;
    logic [7:0]  rdata_in = '0;
    logic        wen_out;
    logic        en_out;

    always #5 sys_clk = ~sys_clk;

    spi_bram_bridge #(.ADDR_W(13), .DATA_W(8), .RD_LATENCY(1)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .sclk_in  (sclk_in),
        .mosi_in  (mosi_in),
        .cs_in    (cs_in),
        .miso_out (miso_out),
        .addr_out (addr_out),
        .wdata_out(wdata_out),
        .rdata_in (rdata_in),
        .wen_out  (wen_out),
        .en_out   (en_out)
    );

    // Behavioural single-port BRAM, one cycle read latency.
    logic [7:0] mem [0:8191];
    initial for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    always @(posedge sys_clk) begin
        if (en_out && wen_out)  mem[addr_out] <= wdata_out;
        if (en_out && !wen_out) rdata_in <= mem[addr_out];
    end

    // Pulse log and MISO activity monitor, sampled mid-cycle.
    typedef struct packed {
        logic [12:0] a;
        logic        w;
        logic [7:0]  d;
    } pulse_t;
    pulse_t pq[$];
    bit     miso_seen;
    always @(negedge sys_clk) begin
        if (en_out) pq.push_back('{a: addr_out, w: wen_out, d: wdata_out});
        if (miso_out) miso_seen = 1'b1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic spi_bit(input logic b, input bit cs_with_rise, output logic r);
        mosi_in = b;
        repeat (HALF) @(negedge sys_clk);
        r = miso_out;
        sclk_in = 1'b1;
        if (cs_with_rise) cs_in = 1'b1;
        repeat (HALF) @(negedge sys_clk);
        sclk_in = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(b[i], 1'b0, r);
            rx[i] = r;
        end
    endtask

    typedef enum int {K_WR, K_RD, K_INV} kind_t;
    typedef struct {
        string       name;
        kind_t       kind;
        logic [7:0]  cmd;
        logic [15:0] addr;
        logic [7:0]  d0, d1;
        logic [12:0] a0, a1, a2;
        logic [7:0]  e0, e1;
    } vec_t;

    task automatic run_frame(input vec_t v);
        logic [7:0] rx0, rx1, junk;
        pq.delete();
        miso_seen = 1'b0;
        cs_in = 1'b0;
        repeat (HALF) @(negedge sys_clk);
        spi_byte(v.cmd, junk);
        spi_byte(v.addr[15:8], junk);
        spi_byte(v.addr[7:0], junk);
        spi_byte(v.d0, rx0);
        spi_byte(v.d1, rx1);
        repeat (HALF) @(negedge sys_clk);
        cs_in = 1'b1;
        repeat (20) @(negedge sys_clk);
        case (v.kind)
            K_WR: begin
                check({v.name, " pulses"}, pq.size(), 2);
                if (pq.size() >= 2) begin
                    check({v.name, " a0"}, pq[0].a, v.a0);
                    check({v.name, " w0"}, pq[0].w, 1);
                    check({v.name, " d0"}, pq[0].d, v.e0);
                    check({v.name, " a1"}, pq[1].a, v.a1);
                    check({v.name, " w1"}, pq[1].w, 1);
                    check({v.name, " d1"}, pq[1].d, v.e1);
                end
            end
            K_RD: begin
                check({v.name, " rx0"}, rx0, v.e0);
                check({v.name, " rx1"}, rx1, v.e1);
                check({v.name, " pulses>=3"}, pq.size() >= 3, 1);
                if (pq.size() >= 3) begin
                    check({v.name, " a0"}, pq[0].a, v.a0);
                    check({v.name, " a1"}, pq[1].a, v.a1);
                    check({v.name, " a2"}, pq[2].a, v.a2);
                    check({v.name, " wen"}, pq[0].w | pq[1].w | pq[2].w, 0);
                end
            end
            default: begin
                check({v.name, " pulses"}, pq.size(), 0);
                check({v.name, " rx0"}, rx0, 8'h00);
                check({v.name, " rx1"}, rx1, 8'h00);
                check({v.name, " miso"}, miso_seen, 0);
            end
        endcase
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " miso"},  miso_out,  0);
        check({tag, " en"},    en_out,    0);
        check({tag, " wen"},   wen_out,   0);
        check({tag, " addr"},  addr_out,  0);
        check({tag, " wdata"}, wdata_out, 0);
    endtask

    vec_t vt[7];
    vec_t vx;
    logic [7:0] junk;
    logic       r;

    initial begin
        vt[0] = '{"wr_burst", K_WR, 8'h02, 16'h0010, 8'hA5, 8'h3C, 13'h0010, 13'h0011, 13'h0000, 8'hA5, 8'h3C};
        vt[1] = '{"rd_burst", K_RD, 8'h03, 16'h0010, 8'h00, 8'h00, 13'h0010, 13'h0011, 13'h0012, 8'hA5, 8'h3C};
        vt[2] = '{"wr_wrap",  K_WR, 8'h02, 16'h1FFF, 8'h11, 8'h22, 13'h1FFF, 13'h0000, 13'h0000, 8'h11, 8'h22};
        vt[3] = '{"rd_wrap",  K_RD, 8'h03, 16'h1FFF, 8'h00, 8'h00, 13'h1FFF, 13'h0000, 13'h0001, 8'h11, 8'h22};
        vt[4] = '{"invalid",  K_INV, 8'h7E, 16'h0010, 8'hFF, 8'hFF, 13'h0000, 13'h0000, 13'h0000, 8'h00, 8'h00};
        vt[5] = '{"wr_trunc", K_WR, 8'h02, 16'hE005, 8'h5A, 8'hC3, 13'h0005, 13'h0006, 13'h0000, 8'h5A, 8'hC3};
        vt[6] = '{"rd_trunc", K_RD, 8'h03, 16'h0005, 8'h00, 8'h00, 13'h0005, 13'h0006, 13'h0007, 8'h5A, 8'hC3};

        // Reset state
        repeat (4) @(negedge sys_clk);
        check_outputs_zero("reset");
        sys_rst = 1'b0;
        repeat (10) @(negedge sys_clk);

        foreach (vt[i]) run_frame(vt[i]);

        // Partial word: 5 data bits then CS high, no write; next frame decodes.
        pq.delete();
        cs_in = 1'b0;
        repeat (HALF) @(negedge sys_clk);
        spi_byte(8'h02, junk);
        spi_byte(8'h00, junk);
        spi_byte(8'h20, junk);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b0, r);
        repeat (HALF) @(negedge sys_clk);
        cs_in = 1'b1;
        repeat (20) @(negedge sys_clk);
        check("partial pulses", pq.size(), 0);
        run_frame(vt[1]);

        // Reset in the middle of a read word with CS held low.
        cs_in = 1'b0;
        repeat (HALF) @(negedge sys_clk);
        spi_byte(8'h03, junk);
        spi_byte(8'h00, junk);
        spi_byte(8'h10, junk);
        for (int i = 0; i < 4; i++) spi_bit(1'b0, 1'b0, r);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check_outputs_zero("midrst");
        @(negedge sys_clk);
        sys_rst = 1'b0;
        pq.delete();
        miso_seen = 1'b0;
        for (int i = 0; i < 12; i++) spi_bit(1'b1, 1'b0, r);
        repeat (HALF) @(negedge sys_clk);
        check("midrst pulses", pq.size(), 0);
        check("midrst miso", miso_seen, 0);
        cs_in = 1'b1;
        repeat (20) @(negedge sys_clk);
        vx = '{"rd_after_rst", K_RD, 8'h03, 16'h0011, 8'h00, 8'h00, 13'h0011, 13'h0012, 13'h0013, 8'h3C, 8'h00};
        run_frame(vx);

        // CS rises on the same cycle as the final data bit's SCLK rise.
        pq.delete();
        cs_in = 1'b0;
        repeat (HALF) @(negedge sys_clk);
        spi_byte(8'h02, junk);
        spi_byte(8'h01, junk);
        spi_byte(8'h00, junk);
        for (int i = 7; i >= 1; i--) spi_bit(logic'(8'h77 >> i), 1'b0, r);
        spi_bit(1'b1, 1'b1, r);
        repeat (20) @(negedge sys_clk);
        check("cs_last pulses", pq.size(), 1);
        if (pq.size() >= 1) begin
            check("cs_last addr", pq[0].a, 13'h0100);
            check("cs_last wen",  pq[0].w, 1);
            check("cs_last data", pq[0].d, 8'h77);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_bram_bridge.md
# spi_bram_bridge

- Parametrised SPI-slave-to-BRAM bridge; next generation of the current SPI/BRAM access path.
- Decodes a command/address/data SPI protocol (mode 0) with configurable address and data widths.
- Supports burst reads and writes with address auto-increment, plus read prefetch for a configurable BRAM read latency.
- Sits between the MCU SPI pins and a single-port block RAM, all in the `sys_clk` domain.

## Interface
- `ADDR_W`, 13, BRAM address width (1..24).
- `DATA_W`, 8, BRAM word width; multiple of 8, 8..32.
- `RD_LATENCY`, 1, sys_clk cycles from `en_out` (with `wen_out` low) to valid `rdata_in` (1..3).
- Derived: `ADDR_BYTES = ceil(ADDR_W/8)`.

Ports:
- `sys_clk`  in  1  system clock; all logic on its rising edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `sclk_in`  in  1  SPI clock, asynchronous, idle low.
- `mosi_in`  in  1  SPI data in, asynchronous.
- `cs_in`  in  1  SPI chip select, active low, asynchronous.
- `miso_out`  out  1  SPI data out.
- `addr_out`  out  ADDR_W  BRAM address.
- `wdata_out`  out  DATA_W  BRAM write data.
- `rdata_in`  in  DATA_W  BRAM read data.
- `wen_out`  out  1  BRAM write enable.
- `en_out`  out  1  BRAM enable.

## Operation
- Synchronisers: `sclk_in`, `mosi_in` and `cs_in` each pass through a 2-FF synchroniser; SCLK rise/fall detected from synchronised samples.
- Bit ordering: MOSI sampled on detected SCLK rise; MISO updated on detected SCLK fall; all fields MSB first.
- Frame layout: 1 command byte, then `ADDR_BYTES` address bytes, then data words of `DATA_W` bits.
- Address width: only the low `ADDR_W` bits of the received address are used.
- Commands: 0x02 = write burst; 0x03 = read burst; anything else = invalid.
- FSM states: IDLE, CMD, ADDR, WDATA, RDATA, DROP, WAIT_CS.
  - IDLE -> CMD on synchronised CS falling.
  - CMD -> ADDR after 8 bits if the command is valid; otherwise CMD -> DROP.
  - ADDR -> WDATA or RDATA after `ADDR_BYTES*8` bits.
  - Any state -> IDLE on synchronised CS high, except WAIT_CS.
  - DROP: ignore SCLK, `miso_out` = 0.
  - WAIT_CS: entered after reset if CS is low; -> IDLE when CS goes high.
- WDATA behaviour:
  - Each completed word raises `en_out` = `wen_out` = 1 for exactly one cycle, with `addr_out` = current address and `wdata_out` = the word.
  - Address then increments modulo 2^ADDR_W.
- RDATA behaviour:
  - On entry, issue a read (`en_out` = 1, `wen_out` = 0, one cycle) at the start address.
  - Capture `rdata_in` RD_LATENCY cycles later into a holding register.
  - On the SCLK fall after the last address bit, load the holding register into the shift register and drive its MSB.
  - Immediately issue a prefetch read of address+1 (wrapping).
  - Each subsequent word boundary repeats the load-and-prefetch step.
- Address wrap: 2^ADDR_W-1 -> 0 in both directions of burst.
- Partial words: CS high mid-word discards the partial word; no BRAM write occurs.
- Reset mid-transaction: all state cleared; FSM enters WAIT_CS if CS is still low, so the in-flight frame is ignored.

## Timing
- Output reset values: `miso_out`, `wen_out`, `en_out` = 0; `addr_out`, `wdata_out` = 0.
- `miso_out` is 0 whenever not in RDATA.
- Input latency: SCLK edge to internal edge detect = 3 sys_clk cycles.
- Write latency: `wen_out` asserts 1 cycle after the edge detect of the word's last bit.
- Rate constraint: SCLK high and low times must each be ≥ RD_LATENCY+4 sys_clk cycles (defaults: SCLK ≤ 10 MHz at 100 MHz `sys_clk`).
- Write-then-CS: CS rising on the same cycle as a final-bit edge detect still completes that write.
- No BRAM access is ever issued in the same cycle as another; at most one `en_out` pulse per word.

## Configuration
- `SPI_BRAM_STATUS_EN` defined: adds command 0x05 (read status).
  - Response: one byte repeated for as long as clocked, = saturating 8-bit count of invalid commands plus discarded partial write words since reset.
  - The count clears on reset.
- `SPI_BRAM_STATUS_EN` undefined: 0x05 is invalid (goes to DROP) and the counter does not exist.

## Test plan
- Write burst: 0x02, 0x00, 0x10, 0xA5, 0x3C -> two single-cycle `wen_out` pulses: addr 0x0010/0xA5, then addr 0x0011/0x3C.
- Read burst (after the write above): 0x03, 0x00, 0x10, then 16 SCLKs -> MISO returns 0xA5, 0x3C; `en_out` pulses at 0x0010, 0x0011, 0x0012 with `wen_out` = 0.
- Wrap: write 0x11, 0x22 at 0x1FFF -> writes land at 0x1FFF, then 0x0000.
- Partial word: 0x02, 0x00, 0x20, then 5 data bits, then CS high -> no `wen_out`; next frame decodes normally.
- Invalid command: 0x7E, then 16 SCLKs -> no `en_out`, `miso_out` = 0 throughout.
  - With `SPI_BRAM_STATUS_EN`: a following 0x05 returns 0x01.
- Reset mid-read: assert `sys_rst` during an RDATA word with CS low -> outputs 0, no BRAM access until CS goes high, and the next 0x03 frame reads correctly.
